addsub_rr_scheduler: RTL and testbench
======================================

Name: addsub_rr_scheduler

Overview:
- Shares one WIDTH-bit combined add/subtract datapath among NUM_REQ requesters.
- Round-robin arbitration selects one operation per cycle and registers its result into a single-entry output slot.
- Each requester has its own valid/ready request channel; all requesters share one valid/ready response channel.
- Sits between client blocks (ALU front-ends, address generators) and the shared arithmetic resource.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 8, operand width in bits; the result is WIDTH+1 bits.
- ID_W, derived localparam (not overridable), equals clog2(NUM_REQ).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester operation valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit set.
- req_a  in  NUM_REQ*WIDTH  packed unsigned operand A; requester i occupies slice [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  packed unsigned operand B, same packing as req_a.
- req_ctrl  in  NUM_REQ  per-requester mode: 1 = A-B, 0 = A+B.
- rsp_valid  out  1  result slot occupied.
- rsp_ready  in  1  consumer accepts the result.
- rsp_y  out  WIDTH+1  two's-complement result.
- rsp_cout  out  1  raw carry out of the WIDTH-bit adder.
- rsp_id  out  ID_W  index of the requester that owns the result.

Behaviour:
- Reset (async assert, sync release):
  - rsp_valid=0, rsp_y=0, rsp_cout=0, rsp_id=0.
  - Round-robin pointer = 0, FSM = EMPTY.
- FSM has two states:
  - EMPTY: slot free.
  - FULL: result held until rsp_ready.
- slot_free = (state==EMPTY) | (rsp_valid & rsp_ready).
- Arbitration (combinational):
  - Search starts at the pointer and wraps modulo NUM_REQ; the first asserted req_valid wins.
  - req_ready[winner] = slot_free. All other req_ready bits are 0.
  - req_ready never depends on rsp_valid except through slot_free; it may combinationally follow req_valid.
- Acceptance (req_valid & req_ready on the same edge):
  - The datapath computes from the winner's operands and the result is registered. Latency is 1 cycle: rsp_valid rises the cycle after acceptance.
  - rsp_id = winner.
  - Pointer = winner+1 modulo NUM_REQ. The pointer holds when nothing is accepted.
- Arithmetic (ripple, B inverted by ctrl, carry-in = ctrl):
  - ctrl=0: rsp_y = {cout, sum}, i.e. the unsigned sum zero-extended with carry.
  - ctrl=1: rsp_y = {~cout, diff}, so a negative difference is sign-extended. rsp_cout = raw carry (1 when A>=B).
- State transitions:
  - EMPTY --accept--> FULL.
  - FULL & rsp_ready & accept --> FULL, slot reloaded back-to-back with no bubble.
  - FULL & rsp_ready & no accept --> EMPTY.
  - FULL & !rsp_ready --> FULL. rsp_y, rsp_cout and rsp_id are held stable.
- Requester-side rules:
  - A requester that deasserts req_valid before acceptance loses nothing; no operation is recorded.
  - Operands are sampled only on the accept edge.
- Simultaneous requests: all requesters are served in rotation. With NUM_REQ requests continuously asserted and rsp_ready=1, each requester gets exactly one grant per NUM_REQ cycles.
- Reset mid-operation: a pending result is discarded, rsp_valid drops immediately (async), and the pointer returns to 0.
- Invariant: no combinational path from rsp_ready to rsp_y, rsp_cout or rsp_id.

Optional Feature:
- Macro: ADDSUB_SCHED_STATS_EN.
- When defined:
  - Adds output ops_count (16 bits): counts accepted operations and saturates at 16'hFFFF.
  - Adds output stall_count (16 bits): counts cycles with rsp_valid & !rsp_ready, saturating.
  - Both counters reset to 0 on rst_n.
- When undefined: both ports and all counter logic are absent, and the block behaves identically otherwise.

Test Plan:
- Reset with all inputs idle -> rsp_valid=0, req_ready=0000, rsp_y=0; pointer=0 after release.
- Single request, WIDTH=8, NUM_REQ=4: req 2, A=5, B=9, ctrl=1 -> next cycle rsp_valid=1, rsp_y=9'h1FC, rsp_cout=0, rsp_id=2.
- Single add: A=8'hFF, B=8'h01, ctrl=0 -> rsp_y=9'h100, rsp_cout=1.
- All four requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0; one result per cycle; no bubble.
- rsp_ready held 0 for 3 cycles with requests pending -> req_ready=0000 and rsp_y stable. rsp_ready returns to 1 -> the next grant goes to the same cycle's winner. With ADDSUB_SCHED_STATS_EN, stall_count=3.
- rst_n asserted while FULL -> rsp_valid falls without waiting for a clock edge; the first grant after release goes to requester 0.

Source files
------------

// File: rtl/addsub_rr_scheduler.sv
// Round-robin scheduler sharing one add/subtract datapath among NUM_REQ requesters.
// Optional statistics counters (ops_count, stall_count) are built when ADDSUB_SCHED_STATS_EN is defined.
module addsub_rr_scheduler #(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = 8,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_ctrl,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH:0]           rsp_y,
    output logic                     rsp_cout,
`ifdef ADDSUB_SCHED_STATS_EN
    output logic [15:0]              ops_count,
    output logic [15:0]              stall_count,
`endif
    output logic [ID_W-1:0]          rsp_id
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [WIDTH:0]  rspY_q, rspY_d;
    logic            rspCout_q, rspCout_d;
    logic [ID_W-1:0] rspId_q, rspId_d;

    logic             slotFree;
    logic             grantFound;
    logic [ID_W-1:0]  grantIdx;
    logic             accept;
    int               arbIdx;

    logic [WIDTH-1:0] opA [NUM_REQ];
    logic [WIDTH-1:0] opB [NUM_REQ];
    logic [WIDTH-1:0] selA, selB, bEff, sum;
    logic             selCtrl;
    logic [WIDTH:0]   carry;
    logic [WIDTH:0]   result;

    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : gUnpack
            assign opA[g] = req_a[g*WIDTH +: WIDTH];
            assign opB[g] = req_b[g*WIDTH +: WIDTH];
        end
    endgenerate

    assign rsp_valid = (state_q == FULL);
    assign slotFree  = (state_q == EMPTY) | (rsp_valid & rsp_ready);

    // Scan requesters starting at the pointer, wrapping around; first valid one wins.
    always_comb begin
        grantFound = 1'b0;
        grantIdx   = '0;
        arbIdx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            arbIdx = int'(ptr_q) + k;
            if (arbIdx >= NUM_REQ) begin
                arbIdx = arbIdx - NUM_REQ;
            end
            if (!grantFound && req_valid[ID_W'(arbIdx)]) begin
                grantFound = 1'b1;
                grantIdx   = ID_W'(arbIdx);
            end
        end
    end

    assign accept = grantFound & slotFree;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grantIdx] = 1'b1;
        end
    end

    assign selA    = opA[grantIdx];
    assign selB    = opB[grantIdx];
    assign selCtrl = req_ctrl[grantIdx];

    // Ripple-carry adder; subtraction inverts B and injects a carry-in of one.
    always_comb begin
        bEff     = selB ^ {WIDTH{selCtrl}};
        sum      = '0;
        carry    = '0;
        carry[0] = selCtrl;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i]     = selA[i] ^ bEff[i] ^ carry[i];
            carry[i+1] = (selA[i] & bEff[i]) | (carry[i] & (selA[i] ^ bEff[i]));
        end
    end

    assign result = {carry[WIDTH] ^ selCtrl, sum};

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        rspY_d    = rspY_q;
        rspCout_d = rspCout_q;
        rspId_d   = rspId_q;

        if (accept) begin
            rspY_d    = result;
            rspCout_d = carry[WIDTH];
            rspId_d   = grantIdx;
            ptr_d     = (grantIdx == ID_W'(NUM_REQ - 1)) ? '0 : grantIdx + 1'b1;
        end

        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (rsp_ready && !accept) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            ptr_q     <= '0;
            rspY_q    <= '0;
            rspCout_q <= 1'b0;
            rspId_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            rspY_q    <= rspY_d;
            rspCout_q <= rspCout_d;
            rspId_q   <= rspId_d;
        end
    end

    assign rsp_y    = rspY_q;
    assign rsp_cout = rspCout_q;
    assign rsp_id   = rspId_q;

`ifdef ADDSUB_SCHED_STATS_EN
    logic [15:0] opsCount_q;
    logic [15:0] stallCount_q;

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opsCount_q   <= '0;
            stallCount_q <= '0;
        end else begin
            if (accept && opsCount_q != 16'hFFFF) begin
                opsCount_q <= opsCount_q + 16'd1;
            end
            if (rsp_valid && !rsp_ready && stallCount_q != 16'hFFFF) begin
                stallCount_q <= stallCount_q + 16'd1;
            end
        end
    end

    assign ops_count   = opsCount_q;
    assign stall_count = stallCount_q;
`endif

endmodule

// File: tb/tb_addsub_rr_scheduler.sv
// Randomized self-checking bench for addsub_rr_scheduler against a transaction-level model.
`timescale 1ns/1ps
module tb_addsub_rr_scheduler;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a = '0;
    logic [N*W-1:0]   req_b = '0;
    logic [N-1:0]     req_ctrl = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [W:0]       rsp_y;
    logic             rsp_cout;
    logic [IDW-1:0]   rsp_id;
`ifdef ADDSUB_SCHED_STATS_EN
    logic [15:0]      ops_count;
    logic [15:0]      stall_count;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: slot contents, rotation pointer, statistics.
    bit         mFull;
    logic [W:0] mY;
    logic       mCout;
    int         mId;
    int         mPtr;
    int         mOps;
    int         mStall;

    addsub_rr_scheduler #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ctrl    (req_ctrl),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_y       (rsp_y),
        .rsp_cout    (rsp_cout),
`ifdef ADDSUB_SCHED_STATS_EN
        .ops_count   (ops_count),
        .stall_count (stall_count),
`endif
        .rsp_id      (rsp_id)
    );

    always #5 clk = ~clk;

    function automatic int modelWinner();
        for (int k = 0; k < N; k++) begin
            int i;
            i = (mPtr + k) % N;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] modelReady();
        int w;
        logic [N-1:0] r;
        r = '0;
        w = modelWinner();
        if (w >= 0 && (!mFull || rsp_ready)) r[w] = 1'b1;
        return r;
    endfunction

    task automatic modelResetState();
        mFull = 0; mY = '0; mCout = 0; mId = 0; mPtr = 0; mOps = 0; mStall = 0;
    endtask

    // Advance the model by one clock using the inputs currently driven, then step the DUT.
    task automatic tick();
        int w;
        logic [W-1:0] a, b;
        w = modelWinner();
        if (mFull && !rsp_ready && mStall < 65535) mStall++;
        if (w >= 0 && (!mFull || rsp_ready)) begin
            a = req_a[w*W +: W];
            b = req_b[w*W +: W];
            if (req_ctrl[w]) begin
                mY    = {1'b0, a} - {1'b0, b};
                mCout = (a >= b);
            end else begin
                mY    = {1'b0, a} + {1'b0, b};
                mCout = mY[W];
            end
            mFull = 1;
            mId   = w;
            mPtr  = (w + 1) % N;
            if (mOps < 65535) mOps++;
        end else if (mFull && rsp_ready) begin
            mFull = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic randOperands();
        req_a    = {$urandom, $urandom};
        req_b    = {$urandom, $urandom};
        req_ctrl = N'($urandom);
    endtask

    task automatic applyReset();
        req_valid = '0;
        rsp_ready = 1'b0;
        #1 rst_n = 1'b0;
        modelResetState();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        req_valid = '0;
        rsp_ready = 1'b0;
        #2 rst_n = 1'b0;
        modelResetState();
        #1;
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_req_ready: got %b expected 0000", req_ready); end
        vectors++; if (rsp_y !== 9'h000) begin miscompares++; $display("[TB] FAIL reset_rsp_y: got %h expected 000", rsp_y); end
        vectors++; if (rsp_cout !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rsp_cout: got %b expected 0", rsp_cout); end
        vectors++; if (rsp_id !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_release_valid: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_single_sub();
        randOperands();
        req_a[2*W +: W] = 8'd5;
        req_b[2*W +: W] = 8'd9;
        req_ctrl[2]     = 1'b1;
        req_valid       = 4'b0100;
        rsp_ready       = 1'b0;
        #1;
        vectors++; if (req_ready !== 4'b0100) begin miscompares++; $display("[TB] FAIL sub_req_ready: got %b expected 0100", req_ready); end
        tick();
        req_valid = '0;
        randOperands();
        #1;
        vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL sub_rsp_valid: got %b expected 1", rsp_valid); end
        vectors++; if (rsp_y !== 9'h1FC) begin miscompares++; $display("[TB] FAIL sub_rsp_y: got %h expected 1fc", rsp_y); end
        vectors++; if (rsp_cout !== 1'b0) begin miscompares++; $display("[TB] FAIL sub_rsp_cout: got %b expected 0", rsp_cout); end
        vectors++; if (rsp_id !== 2'd2) begin miscompares++; $display("[TB] FAIL sub_rsp_id: got %0d expected 2", rsp_id); end
        rsp_ready = 1'b1;
        tick();
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL sub_drain: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_single_add();
        randOperands();
        req_a[1*W +: W] = 8'hFF;
        req_b[1*W +: W] = 8'h01;
        req_ctrl[1]     = 1'b0;
        req_valid       = 4'b0010;
        rsp_ready       = 1'b1;
        #1;
        vectors++; if (req_ready !== 4'b0010) begin miscompares++; $display("[TB] FAIL add_req_ready: got %b expected 0010", req_ready); end
        tick();
        req_valid = '0;
        vectors++; if (rsp_y !== 9'h100) begin miscompares++; $display("[TB] FAIL add_rsp_y: got %h expected 100", rsp_y); end
        vectors++; if (rsp_cout !== 1'b1) begin miscompares++; $display("[TB] FAIL add_rsp_cout: got %b expected 1", rsp_cout); end
        vectors++; if (rsp_id !== 2'd1) begin miscompares++; $display("[TB] FAIL add_rsp_id: got %0d expected 1", rsp_id); end
        tick();
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL add_drain: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_back_to_back();
        applyReset();
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            logic [N-1:0] expRdy;
            expRdy = '0;
            expRdy[c % N] = 1'b1;
            randOperands();
            #1;
            vectors++; if (req_ready !== expRdy) begin miscompares++; $display("[TB] FAIL b2b_req_ready[%0d]: got %b expected %b", c, req_ready, expRdy); end
            tick();
            vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_valid[%0d]: got %b expected 1", c, rsp_valid); end
            vectors++; if (rsp_id !== IDW'(c % N)) begin miscompares++; $display("[TB] FAIL b2b_id[%0d]: got %0d expected %0d", c, rsp_id, c % N); end
            vectors++; if (rsp_y !== mY || rsp_cout !== mCout) begin miscompares++; $display("[TB] FAIL b2b_result[%0d]: got %h/%b expected %h/%b", c, rsp_y, rsp_cout, mY, mCout); end
        end
    endtask

    task automatic test_stall();
        applyReset();
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        randOperands();
        tick();
        rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            randOperands();
            #1;
            vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("[TB] FAIL stall_req_ready[%0d]: got %b expected 0000", c, req_ready); end
            tick();
            vectors++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin miscompares++; $display("[TB] FAIL stall_hold_id[%0d]: got %b/%0d expected 1/0", c, rsp_valid, rsp_id); end
            vectors++; if (rsp_y !== mY || rsp_cout !== mCout) begin miscompares++; $display("[TB] FAIL stall_hold_y[%0d]: got %h/%b expected %h/%b", c, rsp_y, rsp_cout, mY, mCout); end
        end
        rsp_ready = 1'b1;
        #1;
        vectors++; if (req_ready !== 4'b0010) begin miscompares++; $display("[TB] FAIL stall_resume_ready: got %b expected 0010", req_ready); end
`ifdef ADDSUB_SCHED_STATS_EN
        vectors++; if (stall_count !== 16'd3) begin miscompares++; $display("[TB] FAIL stall_count: got %0d expected 3", stall_count); end
        vectors++; if (ops_count !== 16'd1) begin miscompares++; $display("[TB] FAIL stall_ops_count: got %0d expected 1", ops_count); end
`endif
        tick();
        vectors++; if (rsp_id !== 2'd1 || rsp_y !== mY) begin miscompares++; $display("[TB] FAIL stall_resume_result: got %0d/%h expected 1/%h", rsp_id, rsp_y, mY); end
    endtask

    task automatic test_reset_mid();
        #2 rst_n = 1'b0;
        modelResetState();
        #1;
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_valid: got %b expected 0", rsp_valid); end
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        randOperands();
        #1;
        vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("[TB] FAIL midreset_first_ready: got %b expected 0001", req_ready); end
        tick();
        vectors++; if (rsp_id !== 2'd0 || rsp_y !== mY) begin miscompares++; $display("[TB] FAIL midreset_first_grant: got %0d/%h expected 0/%h", rsp_id, rsp_y, mY); end
    endtask

    task automatic test_withdraw();
        rsp_ready = 1'b0;
        req_valid = 4'b0100;
        randOperands();
        #1;
        vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("[TB] FAIL withdraw_ready: got %b expected 0000", req_ready); end
        tick();
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
        vectors++; if (rsp_valid !== 1'b0 || rsp_id !== 2'd0) begin miscompares++; $display("[TB] FAIL withdraw_no_op: got %b/%0d expected 0/0", rsp_valid, rsp_id); end
`ifdef ADDSUB_SCHED_STATS_EN
        vectors++; if (ops_count !== 16'(mOps)) begin miscompares++; $display("[TB] FAIL withdraw_ops_count: got %0d expected %0d", ops_count, mOps); end
`endif
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            logic [N-1:0] expRdy;
            req_valid = N'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            randOperands();
            #1;
            expRdy = modelReady();
            vectors++; if (req_ready !== expRdy) begin miscompares++; $display("[TB] FAIL rand_req_ready[%0d]: got %b expected %b", c, req_ready, expRdy); end
            tick();
            vectors++; if (rsp_valid !== mFull) begin miscompares++; $display("[TB] FAIL rand_valid[%0d]: got %b expected %b", c, rsp_valid, mFull); end
            vectors++; if (rsp_y !== mY || rsp_cout !== mCout || rsp_id !== IDW'(mId)) begin miscompares++; $display("[TB] FAIL rand_result[%0d]: got %h/%b/%0d expected %h/%b/%0d", c, rsp_y, rsp_cout, rsp_id, mY, mCout, mId); end
        end
`ifdef ADDSUB_SCHED_STATS_EN
        vectors++; if (ops_count !== 16'(mOps) || stall_count !== 16'(mStall)) begin miscompares++; $display("[TB] FAIL rand_counters: got %0d/%0d expected %0d/%0d", ops_count, stall_count, mOps, mStall); end
`endif
    endtask

    initial begin
        modelResetState();
        test_reset();
        test_single_sub();
        test_single_add();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_withdraw();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
